// File: rtl/uart_xcvr.sv
// uart_xcvr: full-duplex UART transceiver (independent TX and RX paths).
//
// Frame on the line: start bit (0), DATA_BITS payload bits LSB first, an
// optional parity bit, then the stop bit(s) (1). The line idles high.
//
// Ports
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   tx_data        payload to transmit
//   tx_valid       tx_data is valid
//   tx_ready       transmitter idle and able to take a byte
//   tx             serial output, idles high
//   rx             serial input, asynchronous to clk
//   rx_data        last received payload
//   rx_valid       rx_data holds a byte not yet consumed
//   rx_ready       consumer takes the byte
//   rx_parity_err  parity mismatch on the byte in rx_data
//   rx_frame_err   first stop bit sampled low on the byte in rx_data
//   rx_overrun     an unconsumed byte was overwritten
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds data stable while valid is high and ready is
// low. tx_valid is ignored while tx_ready is low. RX has no back-pressure:
// a new frame overwrites an unconsumed byte and raises rx_overrun.
module uart_xcvr #(
  parameter int CLK_HZ     = 100000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
);

  localparam int TICK_HZ = BAUD * OVERSAMPLE;
  localparam int DIV_RAW = (CLK_HZ + TICK_HZ / 2) / TICK_HZ;
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW      = $clog2(OVERSAMPLE);

  localparam logic [CW-1:0] BIT_LAST  = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic          ODD       = (PARITY == 1);
  localparam logic          HAS_PAR   = (PARITY != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // ---------------------------------------------------------------------
  // Oversampling tick: one clk pulse every DIV clocks, shared by TX and RX.
  // ---------------------------------------------------------------------
  logic [DW-1:0] div_cnt;
  logic          tick;

  assign tick = (div_cnt == DW'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + DW'(1);
  end

  // ---------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------
  state_t                tx_state, tx_state_n;
  logic                  tx_loaded, tx_loaded_n;  // byte captured, waiting for a tick
  logic [DATA_BITS-1:0]  tx_sh, tx_sh_n;
  logic                  tx_par, tx_par_n;
  logic [CW-1:0]         tx_bcnt, tx_bcnt_n;      // ticks elapsed within current bit
  logic [3:0]            tx_idx, tx_idx_n;        // data bit or stop bit index
  logic                  tx_q, tx_n;
  logic                  tx_bit_end;

  assign tx_ready   = (tx_state == S_IDLE) && !tx_loaded;
  assign tx         = tx_q;
  assign tx_bit_end = tick && (tx_bcnt == BIT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state  <= S_IDLE;
      tx_loaded <= 1'b0;
      tx_sh     <= '0;
      tx_par    <= 1'b0;
      tx_bcnt   <= '0;
      tx_idx    <= '0;
      tx_q      <= 1'b1;
    end else begin
      tx_state  <= tx_state_n;
      tx_loaded <= tx_loaded_n;
      tx_sh     <= tx_sh_n;
      tx_par    <= tx_par_n;
      tx_bcnt   <= tx_bcnt_n;
      tx_idx    <= tx_idx_n;
      tx_q      <= tx_n;
    end
  end

  // The line level is registered; each branch that changes state also sets
  // the level of the bit being entered so tx changes on the bit-start tick.
  always_comb begin
    tx_state_n  = tx_state;
    tx_loaded_n = tx_loaded;
    tx_sh_n     = tx_sh;
    tx_par_n    = tx_par;
    tx_bcnt_n   = tx_bcnt;
    tx_idx_n    = tx_idx;
    tx_n        = tx_q;

    if (tx_state != S_IDLE && tick)
      tx_bcnt_n = tx_bit_end ? '0 : tx_bcnt + CW'(1);

    case (tx_state)
      S_IDLE: begin
        tx_n = 1'b1;
        if (tx_valid && tx_ready) begin
          tx_loaded_n = 1'b1;
          tx_sh_n     = tx_data;
          tx_par_n    = (^tx_data) ^ ODD;
        end else if (tx_loaded && tick) begin
          tx_state_n  = S_START;
          tx_loaded_n = 1'b0;
          tx_bcnt_n   = '0;
          tx_n        = 1'b0;
        end
      end
      S_START: begin
        if (tx_bit_end) begin
          tx_state_n = S_DATA;
          tx_idx_n   = '0;
          tx_n       = tx_sh[0];
        end
      end
      S_DATA: begin
        if (tx_bit_end) begin
          if (tx_idx == DATA_LAST) begin
            tx_idx_n = '0;
            if (HAS_PAR) begin
              tx_state_n = S_PARITY;
              tx_n       = tx_par;
            end else begin
              tx_state_n = S_STOP;
              tx_n       = 1'b1;
            end
          end else begin
            tx_idx_n = tx_idx + 4'd1;
            tx_sh_n  = tx_sh >> 1;
            tx_n     = tx_sh[1];
          end
        end
      end
      S_PARITY: begin
        if (tx_bit_end) begin
          tx_state_n = S_STOP;
          tx_idx_n   = '0;
          tx_n       = 1'b1;
        end
      end
      S_STOP: begin
        if (tx_bit_end) begin
          if (tx_idx == STOP_LAST) begin
            tx_state_n = S_IDLE;
          end else begin
            tx_idx_n = tx_idx + 4'd1;
          end
          tx_n = 1'b1;
        end
      end
      default: begin
        tx_state_n = S_IDLE;
        tx_n       = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------
  logic rx_s1, rxs;

  // Two-flop synchroniser; resets to the idle line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rxs   <= rx_s1;
    end
  end

  state_t               rx_state, rx_state_n;
  logic                 rx_armed, rx_armed_n;   // line seen high since last frame/reset
  logic [DATA_BITS-1:0] rx_sh, rx_sh_n;
  logic                 rx_perr, rx_perr_n;     // parity status of frame in flight
  logic [CW-1:0]        rx_bcnt, rx_bcnt_n;
  logic [3:0]           rx_idx, rx_idx_n;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_n;
  logic                 rx_valid_q, rx_valid_n;
  logic                 rx_perr_q, rx_perr_out_n;
  logic                 rx_ferr_q, rx_ferr_n;
  logic                 rx_ovr_q, rx_ovr_n;
  logic                 rx_bit_end, rx_half;

  assign rx_bit_end    = tick && (rx_bcnt == BIT_LAST);
  assign rx_half       = tick && (rx_bcnt == HALF_LAST);
  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_parity_err = rx_perr_q;
  assign rx_frame_err  = rx_ferr_q;
  assign rx_overrun    = rx_ovr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state   <= S_IDLE;
      rx_armed   <= 1'b0;
      rx_sh      <= '0;
      rx_perr    <= 1'b0;
      rx_bcnt    <= '0;
      rx_idx     <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end else begin
      rx_state   <= rx_state_n;
      rx_armed   <= rx_armed_n;
      rx_sh      <= rx_sh_n;
      rx_perr    <= rx_perr_n;
      rx_bcnt    <= rx_bcnt_n;
      rx_idx     <= rx_idx_n;
      rx_data_q  <= rx_data_n;
      rx_valid_q <= rx_valid_n;
      rx_perr_q  <= rx_perr_out_n;
      rx_ferr_q  <= rx_ferr_n;
      rx_ovr_q   <= rx_ovr_n;
    end
  end

  always_comb begin
    rx_state_n    = rx_state;
    rx_armed_n    = rx_armed;
    rx_sh_n       = rx_sh;
    rx_perr_n     = rx_perr;
    rx_bcnt_n     = rx_bcnt;
    rx_idx_n      = rx_idx;
    rx_data_n     = rx_data_q;
    rx_valid_n    = rx_valid_q;
    rx_perr_out_n = rx_perr_q;
    rx_ferr_n     = rx_ferr_q;
    rx_ovr_n      = rx_ovr_q;

    // Consumption clears the output side; a frame completing in the same
    // clk overrides these below.
    if (rx_valid_q && rx_ready) begin
      rx_valid_n    = 1'b0;
      rx_ovr_n      = 1'b0;
      rx_perr_out_n = 1'b0;
      rx_ferr_n     = 1'b0;
    end

    if (rx_state != S_IDLE && tick)
      rx_bcnt_n = rx_bit_end ? '0 : rx_bcnt + CW'(1);

    case (rx_state)
      S_IDLE: begin
        // A start bit is a falling edge: the line must be seen high first.
        if (rxs) begin
          rx_armed_n = 1'b1;
        end else if (rx_armed) begin
          rx_state_n = S_START;
          rx_bcnt_n  = '0;
          rx_perr_n  = 1'b0;
        end
      end
      S_START: begin
        if (rx_half) begin
          if (rxs) begin
            rx_state_n = S_IDLE;          // glitch, not a start bit
          end else begin
            rx_state_n = S_DATA;          // now aligned to mid-bit
            rx_bcnt_n  = '0;
            rx_idx_n   = '0;
          end
        end
      end
      S_DATA: begin
        if (rx_bit_end) begin
          rx_sh_n = {rxs, rx_sh[DATA_BITS-1:1]};
          if (rx_idx == DATA_LAST) begin
            rx_state_n = HAS_PAR ? S_PARITY : S_STOP;
          end else begin
            rx_idx_n = rx_idx + 4'd1;
          end
        end
      end
      S_PARITY: begin
        if (rx_bit_end) begin
          rx_perr_n  = ((^rx_sh) ^ rxs) != ODD;
          rx_state_n = S_STOP;
        end
      end
      S_STOP: begin
        if (rx_bit_end) begin
          rx_data_n     = rx_sh;
          rx_valid_n    = 1'b1;
          rx_perr_out_n = rx_perr;
          rx_ferr_n     = !rxs;
          rx_ovr_n      = rx_valid_q && !rx_ready;
          rx_state_n    = S_IDLE;
          // A low stop bit (break) must release before the next start.
          rx_armed_n    = rxs;
        end
      end
      default: begin
        rx_state_n = S_IDLE;
      end
    endcase
  end

endmodule
